// File: rtl/audio_pkg.sv
// Shared definitions for the PCM audio player: sequencer states and default timing/width.
package audio_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWait,
        StPlay
    } state_e;

    // 25 MHz master clock / 10 kHz sampling rate
    localparam int unsigned DEFAULT_CLK_DIV  = 2500;
    localparam int unsigned DEFAULT_SAMPLE_W = 8;

endpackage

// File: rtl/pwm_modulator.sv
// Free-running PWM counter and registered comparator; counter and output held at zero when idle.
module pwm_modulator #(
    parameter int unsigned SAMPLE_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic [SAMPLE_W-1:0] i_duty,
    output logic                o_pwm
);

    logic [SAMPLE_W-1:0] r_cnt;
    logic                r_pwm;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
            r_pwm <= (r_cnt < i_duty);
        end else begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_audio_player.sv
// PCM player: fetches one ROM sample per sampling tick between start/end and drives a PWM pin.
// Build macro AUDIO_VOLUME_EN adds the Atten_In port (duty = sample >> Atten_In).
module pwm_audio_player
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEFAULT_CLK_DIV,
    parameter int unsigned SAMPLE_W = DEFAULT_SAMPLE_W,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic                Master_Clock_In,
    input  logic                Master_Reset_N_In,
    input  logic                Play_In,
    input  logic                Stop_In,
    input  logic                Loop_In,
    input  logic [ADDR_W-1:0]   Start_Addr_In,
    input  logic [ADDR_W-1:0]   End_Addr_In,
    output logic [ADDR_W-1:0]   Rom_Addr_Out,
    input  logic [SAMPLE_W-1:0] Rom_Data_In,
`ifdef AUDIO_VOLUME_EN
    input  logic [2:0]          Atten_In,
`endif
    output logic                Signal_Out,
    output logic                Busy_Out,
    output logic                Done_Out
);

    localparam int unsigned TICK_W = $clog2(CLK_DIV);

    state_e              r_state, w_state_d;
    logic [ADDR_W-1:0]   r_addr, w_addr_d;
    logic [ADDR_W-1:0]   r_start, w_start_d;
    logic [ADDR_W-1:0]   r_end, w_end_d;
    logic [SAMPLE_W-1:0] r_next, w_next_d;
    logic [SAMPLE_W-1:0] r_duty, w_duty_d;
    logic [TICK_W-1:0]   r_tick, w_tick_d;
    logic                r_busy, w_busy_d;
    logic                r_done, w_done_d;
    logic                r_last, w_last_d;
    logic                w_tick;
    logic [SAMPLE_W-1:0] w_scaled;

    assign w_tick = r_busy && (r_tick == TICK_W'(CLK_DIV - 1));

`ifdef AUDIO_VOLUME_EN
    assign w_scaled = r_next >> Atten_In;
`else
    assign w_scaled = r_next;
`endif

    always_comb begin
        w_state_d = r_state;
        w_addr_d  = r_addr;
        w_start_d = r_start;
        w_end_d   = r_end;
        w_next_d  = r_next;
        w_duty_d  = r_duty;
        w_tick_d  = r_busy ? (w_tick ? '0 : r_tick + 1'b1) : '0;
        w_busy_d  = r_busy;
        w_done_d  = 1'b0;
        w_last_d  = r_last;

        if (Stop_In) begin
            w_state_d = StIdle;
            w_busy_d  = 1'b0;
            w_last_d  = 1'b0;
            w_tick_d  = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (Play_In) begin
                        w_start_d = Start_Addr_In;
                        w_end_d   = End_Addr_In;
                        w_addr_d  = Start_Addr_In;
                        w_tick_d  = '0;
                        w_busy_d  = 1'b1;
                        w_duty_d  = '0;
                        w_last_d  = 1'b0;
                        w_state_d = StFetch;
                    end
                end
                StFetch: w_state_d = StWait;
                StWait: begin
                    w_next_d  = Rom_Data_In;
                    w_state_d = StPlay;
                end
                StPlay: begin
                    if (w_tick) begin
                        // r_last: final sample has had its full tick period
                        if (r_last) begin
                            w_done_d  = 1'b1;
                            w_busy_d  = 1'b0;
                            w_last_d  = 1'b0;
                            w_state_d = StIdle;
                        end else begin
                            w_duty_d = w_scaled;
                            if (r_addr == r_end) begin
                                if (Loop_In) begin
                                    w_addr_d  = r_start;
                                    w_state_d = StFetch;
                                end else begin
                                    w_last_d = 1'b1;
                                end
                            end else begin
                                w_addr_d  = r_addr + 1'b1;
                                w_state_d = StFetch;
                            end
                        end
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Master_Clock_In or negedge Master_Reset_N_In) begin
        if (!Master_Reset_N_In) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_start <= '0;
            r_end   <= '0;
            r_next  <= '0;
            r_duty  <= '0;
            r_tick  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_addr  <= w_addr_d;
            r_start <= w_start_d;
            r_end   <= w_end_d;
            r_next  <= w_next_d;
            r_duty  <= w_duty_d;
            r_tick  <= w_tick_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
            r_last  <= w_last_d;
        end
    end

    // Next-state busy so the PWM output drops on the same edge as Stop/Done
    pwm_modulator #(
        .SAMPLE_W (SAMPLE_W)
    ) u_pwm (
        .i_clk   (Master_Clock_In),
        .i_rst_n (Master_Reset_N_In),
        .i_en    (w_busy_d),
        .i_duty  (r_duty),
        .o_pwm   (Signal_Out)
    );

    assign Rom_Addr_Out = r_addr;
    assign Busy_Out     = r_busy;
    assign Done_Out     = r_done;

endmodule

// File: tb/tb_pwm_audio_player.sv
// Bench for pwm_audio_player: per-tick duty measured as high-count of Signal_Out over one period.
module tb_pwm_audio_player;

    localparam int unsigned CLK_DIV  = 256;
    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned ADDR_W   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              play, stop, loop_lvl;
    logic [ADDR_W-1:0] start_addr, end_addr, rom_addr;
    logic [SAMPLE_W-1:0] rom_data;
    logic              sig, busy, done;
`ifdef AUDIO_VOLUME_EN
    logic [2:0]        atten;
`endif

    logic [7:0] rom_mem [256];
    int checks = 0;
    int failures = 0;
    int cur_atten = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr[7:0]];

    pwm_audio_player #(
        .CLK_DIV  (CLK_DIV),
        .SAMPLE_W (SAMPLE_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .Master_Clock_In   (clk),
        .Master_Reset_N_In (rst_n),
        .Play_In           (play),
        .Stop_In           (stop),
        .Loop_In           (loop_lvl),
        .Start_Addr_In     (start_addr),
        .End_Addr_In       (end_addr),
        .Rom_Addr_Out      (rom_addr),
        .Rom_Data_In       (rom_data),
`ifdef AUDIO_VOLUME_EN
        .Atten_In          (atten),
`endif
        .Signal_Out        (sig),
        .Busy_Out          (busy),
        .Done_Out          (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < 256; i++) rom_mem[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    endtask

    // Address of the i-th played sample (1-based), wrapping through 2**16 and looping at end
    function automatic logic [15:0] addr_of(input logic [15:0] s, input int n, input int i);
        return s + 16'((i - 1) % n);
    endfunction

    task automatic start_play(input logic [15:0] s, input logic [15:0] e);
        @(negedge clk);
        start_addr = s;
        end_addr   = e;
        play       = 1'b1;
        step();
        play       = 1'b0;
        start_addr = 16'($urandom);
        end_addr   = 16'($urandom);
    endtask

    // k_clear = 0: one-shot; otherwise Loop_In held high until update k_clear has been checked
    task automatic run(input logic [15:0] s, input logic [15:0] e, input int k_clear);
        logic [15:0] diff, a, a_nxt;
        int n, m, cnt, bad, duty;
        diff = e - s;
        n = int'(diff) + 1;
        m = k_clear + 1;
        while (addr_of(s, n, m) != e) m++;
        loop_lvl = (k_clear > 0);
        start_play(s, e);
        chk("addr_after_play", 32'(rom_addr), 32'(s));
        chk("busy_after_play", 32'(busy), 32'd1);
        repeat (CLK_DIV) step();
        for (int k = 1; k <= m; k++) begin
            a = addr_of(s, n, k);
            duty = int'(rom_mem[a[7:0]]) >> cur_atten;
            a_nxt = (k < m) ? addr_of(s, n, k + 1) : e;
            cnt = 0;
            bad = 0;
            for (int j = 1; j <= int'(CLK_DIV); j++) begin
                step();
                if (j == 1) begin
                    chk("rom_addr", 32'(rom_addr), 32'(a_nxt));
                    if (k == k_clear) loop_lvl = 1'b0;
                end
                if (k == m && j == int'(CLK_DIV)) begin
                    chk("done_pulse", 32'(done), 32'd1);
                    chk("busy_end", 32'(busy), 32'd0);
                    chk("signal_end", 32'(sig), 32'd0);
                end else begin
                    cnt += int'(sig);
                    if (done !== 1'b0 || busy !== 1'b1) bad++;
                end
            end
            chk("busy_done_stable", 32'(bad), 32'd0);
            if (k < m) chk("duty_window", 32'(cnt), 32'(duty));
            else chk("last_duty_window", 32'(cnt == duty || cnt == duty - 1), 32'd1);
        end
        step();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int dcount;
        logic [15:0] rs;
        int rlen, rk;
        rst_n = 1'b1;
        play = 1'b0;
        stop = 1'b0;
        loop_lvl = 1'b0;
        start_addr = '0;
        end_addr = '0;
`ifdef AUDIO_VOLUME_EN
        atten = 3'd0;
`endif
        fill_const(8'h00);
        #1 rst_n = 1'b0;
        #22;
        chk("rst_signal", 32'(sig), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) step();
        chk("idle_signal", 32'(sig), 32'd0);

        // Ramp data equal to the address low byte
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i);
        run(16'h0010, 16'h0013, 0);
        run(16'h0010, 16'h0013, 6);
        run(16'hFFFE, 16'h0001, 0);

        fill_const(8'h40);
        run(16'h0200, 16'h0201, 0);
        fill_const(8'h00);
        run(16'h0300, 16'h0300, 0);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            rs = 16'($urandom);
            rlen = int'($urandom_range(1, 3));
            rk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
            run(rs, rs + 16'(rlen - 1), rk);
        end

        // Play while busy is ignored, then Stop mid-PLAY
        fill_const(8'hFF);
        loop_lvl = 1'b0;
        start_play(16'h0020, 16'h0030);
        repeat (300) step();
        chk("addr_mid", 32'(rom_addr), 32'h21);
        @(negedge clk);
        play = 1'b1;
        start_addr = 16'h0080;
        step();
        play = 1'b0;
        chk("play_ignored_addr", 32'(rom_addr), 32'h21);
        chk("play_ignored_busy", 32'(busy), 32'd1);
        repeat (100) step();
        @(negedge clk) stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_signal", 32'(sig), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        dcount = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (done !== 1'b0 || sig !== 1'b0) dcount++;
        end
        chk("stop_quiet", 32'(dcount), 32'd0);
        @(negedge clk);
        stop = 1'b1;
        play = 1'b1;
        start_addr = 16'h0040;
        step();
        stop = 1'b0;
        play = 1'b0;
        step();
        chk("stop_play_busy", 32'(busy), 32'd0);
        chk("stop_play_addr", 32'(rom_addr), 32'h21);

        // Asynchronous reset off the clock edge
        start_play(16'h0050, 16'h0060);
        repeat (400) step();
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_signal", 32'(sig), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_addr", 32'(rom_addr), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) step();

`ifdef AUDIO_VOLUME_EN
        atten = 3'd2;
        cur_atten = 2;
        fill_const(8'h80);
        run(16'h0070, 16'h0071, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
